// File: rtl/addsub_pipe_flags.sv
`default_nettype none
// ============================================================================
// Module   : addsub_pipe_flags
// Brief    : Pipelined N-bit add/sub, carry chain split into STAGES chunks,
//            with carry/overflow/zero/negative flags and signed saturation.
// Revision : 1.0 - initial release
// ============================================================================
module addsub_pipe_flags #(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [1:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Sum,
    output logic         carry_flag,
    output logic         overflow_flag,
    output logic         zero_flag,
    output logic         negative_flag
);

    localparam int c_w = N / STAGES;

    logic w_adv;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    // Stage k consumes the low chunk of its remaining operands and appends the
    // chunk result above the sum bits already produced by earlier stages.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int c_iw = N - k * c_w;

        logic [c_iw-1:0]        w_a;
        logic [c_iw-1:0]        w_b;
        logic [(k+1)*c_w-1:0]   w_s;
        logic                   w_ci;
        logic                   w_v;
        logic                   w_sat;
        logic [c_w:0]           w_chunk;

        assign w_chunk = {1'b0, w_a[c_w-1:0]} + {1'b0, w_b[c_w-1:0]}
                       + {{c_w{1'b0}}, w_ci};

        if (k == 0) begin : g_src_in
            assign w_a   = A;
            assign w_b   = op[0] ? ~B : B;
            assign w_ci  = op[0];
            assign w_v   = in_valid;
            assign w_sat = op[1];
            assign w_s   = w_chunk[c_w-1:0];
        end else begin : g_src_prev
            assign w_a   = g_stage[k-1].g_mid.r_a;
            assign w_b   = g_stage[k-1].g_mid.r_b;
            assign w_ci  = g_stage[k-1].g_mid.r_cy;
            assign w_v   = g_stage[k-1].g_mid.r_v;
            assign w_sat = g_stage[k-1].g_mid.r_sat;
            assign w_s   = {w_chunk[c_w-1:0], g_stage[k-1].g_mid.r_s};
        end

        if (k < STAGES - 1) begin : g_mid
            logic [c_iw-c_w-1:0]   r_a;
            logic [c_iw-c_w-1:0]   r_b;
            logic [(k+1)*c_w-1:0]  r_s;
            logic                  r_cy;
            logic                  r_v;
            logic                  r_sat;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a   <= '0;
                    r_b   <= '0;
                    r_s   <= '0;
                    r_cy  <= 1'b0;
                    r_v   <= 1'b0;
                    r_sat <= 1'b0;
                end else if (w_adv) begin
                    r_v <= w_v;
                    if (w_v) begin
                        r_a   <= w_a[c_iw-1:c_w];
                        r_b   <= w_b[c_iw-1:c_w];
                        r_s   <= w_s;
                        r_cy  <= w_chunk[c_w];
                        r_sat <= w_sat;
                    end
                end
            end
        end else begin : g_last
            logic         w_cout;
            logic         w_cmsb;
            logic         w_ovf;
            logic [N-1:0] w_res;

            // Carry into the MSB is recovered from the MSB sum bit and its operands.
            assign w_cout = w_chunk[c_w];
            assign w_cmsb = w_chunk[c_w-1] ^ w_a[c_w-1] ^ w_b[c_w-1];
            assign w_ovf  = w_cmsb ^ w_cout;

            always_comb begin
                w_res = w_s;
                if (w_sat && w_ovf) begin
                    w_res = w_s[N-1] ? {1'b0, {(N-1){1'b1}}} : {1'b1, {(N-1){1'b0}}};
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid     <= 1'b0;
                    Sum           <= '0;
                    carry_flag    <= 1'b0;
                    overflow_flag <= 1'b0;
                    zero_flag     <= 1'b0;
                    negative_flag <= 1'b0;
                end else if (w_adv) begin
                    out_valid <= w_v;
                    if (w_v) begin
                        Sum           <= w_res;
                        carry_flag    <= w_cout;
                        overflow_flag <= w_ovf;
                        zero_flag     <= (w_res == '0);
                        negative_flag <= w_res[N-1];
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_addsub_pipe_flags.sv
`default_nettype none
// ============================================================================
// Module   : tb_addsub_pipe_flags
// Brief    : Scoreboard bench for addsub_pipe_flags (N=4, STAGES=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_addsub_pipe_flags;

    localparam int N      = 4;
    localparam int STAGES = 2;

    // Expected byte: {Sum[3:0], carry, overflow, zero, negative}
    localparam logic [1:0] V_OP [9] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd0};
    localparam logic [3:0] V_A  [9] = '{4'h5, 4'hF, 4'hA, 4'h0, 4'h0, 4'h3, 4'h7, 4'h8, 4'h7};
    localparam logic [3:0] V_B  [9] = '{4'hC, 4'hF, 4'hF, 4'h0, 4'h1, 4'h3, 4'h1, 4'h1, 4'h1};
    localparam logic [7:0] V_E  [9] = '{8'h18, 8'hE9, 8'h99, 8'h02, 8'hF1, 8'h0A, 8'h74, 8'h8D, 8'h85};

    typedef struct packed {
        logic [7:0] exp;
        logic       chk;
        int         acc;
    } sb_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [1:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] Sum;
    logic         carry_flag;
    logic         overflow_flag;
    logic         zero_flag;
    logic         negative_flag;
    logic [7:0]   obs;

    sb_t sb[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc   = 0;

    assign obs = {Sum, carry_flag, overflow_flag, zero_flag, negative_flag};

    addsub_pipe_flags #(.N(N), .STAGES(STAGES)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .A             (A),
        .B             (B),
        .op            (op),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .Sum           (Sum),
        .carry_flag    (carry_flag),
        .overflow_flag (overflow_flag),
        .zero_flag     (zero_flag),
        .negative_flag (negative_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got 0x%0h, expected no output", obs);
            end else if (out_ready) begin
                check("result", 32'(obs), 32'(sb[0].exp));
                if (sb[0].chk) check("latency", 32'(cyc - sb[0].acc), 32'(STAGES));
                void'(sb.pop_front());
            end else begin
                check("held_result", 32'(obs), 32'(sb[0].exp));
            end
        end
    end

    // Call just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [1:0] o, input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] e, input logic chk);
        int guard = 0;
        in_valid = 1'b1;
        op = o;
        A  = a;
        B  = b;
        @(negedge clk);
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: in_ready got 0 for %0d cycles, expected 1", guard);
            in_valid = 1'b0;
        end else begin
            sb.push_back('{exp: e, chk: chk, acc: cyc});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int guard = 0;
        in_valid = 1'b0;
        while (sb.size() != 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = '0;
        B         = '0;
        op        = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_outputs", 32'(obs), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Isolated ADD/SUB/saturation vectors
        for (int i = 0; i < 9; i++) begin
            issue(V_OP[i], V_A[i], V_B[i], V_E[i], 1'b1);
            idle();
        end
        drain();

        // Back-to-back ADD vectors
        for (int i = 0; i < 4; i++) begin
            issue(V_OP[i], V_A[i], V_B[i], V_E[i], 1'b1);
        end
        drain();

        // Backpressure with three transactions in flight
        out_ready = 1'b0;
        issue(2'd0, 4'h3, 4'h4, 8'h70, 1'b0);
        issue(2'd1, 4'h5, 4'h7, 8'hE1, 1'b0);
        in_valid = 1'b1;
        op = 2'd3;
        A  = 4'h7;
        B  = 4'h8;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(2'd3, 4'h7, 4'h8, 8'h74, 1'b0);
        drain();

        // Reset one cycle after acceptance flushes the transaction
        issue(2'd0, 4'h5, 4'hC, 8'h18, 1'b1);
        in_valid = 1'b0;
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        repeat (3) begin
            check("flush_out_valid", 32'(out_valid), 32'd0);
            check("flush_outputs", 32'(obs), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        issue(2'd0, 4'h1, 4'h1, 8'h20, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
